// File: rtl/axi4_lite_cmd_sequencer.sv
// axi4_lite_cmd_sequencer: FIFO-buffered command issuer for the AXI4-Lite top.
// Optional read timeout enabled by defining AXIL_SEQ_TIMEOUT_EN.
module axi4_lite_cmd_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS    = 32,
  parameter int DEPTH      = 4,
  parameter int WR_WAIT    = 8,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDRESS-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata,
  output logic                   read_s,
  output logic                   write_s,
  output logic [ADDRESS-1:0]     address,
  output logic [DATA_WIDTH-1:0]  W_data,
  input  logic [DATA_WIDTH-1:0]  read_data_out,
  input  logic                   read_valid_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] cmd_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(WR_WAIT > RD_TIMEOUT ? WR_WAIT : RD_TIMEOUT) + 1;
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_RD = 3'd2, WAIT_WR = 3'd3, RESP = 3'd4;
  logic [2:0] state;
  logic [AW-1:0] wp, rp;
  logic fifo_write [DEPTH];
  logic [ADDRESS-1:0] fifo_addr [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [DEPTH];
  logic cmd_w;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign cmd_ready = cmd_count < NW'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && cmd_count != '0;
  assign read_s = state == ISSUE && !cmd_w;
  assign write_s = state == ISSUE && cmd_w;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  // command storage; contents need no reset since occupancy gates every read
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_write[wp] <= cmd_write;
      fifo_addr[wp] <= cmd_addr;
      fifo_wdata[wp] <= cmd_wdata;
    end
  end
  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wp <= '0;
      rp <= '0;
      cmd_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cmd_count <= cmd_count + NW'(push) - NW'(pop);
    end
  end
  // issue FSM: one command in flight, response held until the client takes it
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      cmd_w <= 1'b0;
      address <= '0;
      W_data <= '0;
      cnt <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          cmd_w <= fifo_write[rp];
          address <= fifo_addr[rp];
          W_data <= fifo_wdata[rp];
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= cmd_w ? CW'(WR_WAIT - 1) : CW'(RD_TIMEOUT - 2);
          state <= cmd_w ? WAIT_WR : WAIT_RD;
        end
        WAIT_RD: if (read_valid_out) begin
          rsp_write <= 1'b0;
          rsp_rdata <= read_data_out;
          rsp_err <= 1'b0;
          state <= RESP;
        end
`ifdef AXIL_SEQ_TIMEOUT_EN
        else if (cnt == '0) begin
          rsp_write <= 1'b0;
          rsp_rdata <= '0;
          rsp_err <= 1'b1;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
`endif
        WAIT_WR: if (cnt == '0) begin
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_err <= 1'b0;
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// tb_axi4_lite_cmd_sequencer: vector table, hand-built corner sequences and random traffic against a transaction-level model
module tb_axi4_lite_cmd_sequencer;
  localparam int DW = 32, AW = 32, DEPTH = 4, WR_WAIT = 8, RD_TIMEOUT = 64;
  logic ACLK = 0, ARESETN = 0;
  logic cmd_valid = 0, cmd_write = 0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0, address;
  logic [DW-1:0] cmd_wdata = '0, W_data, rsp_rdata;
  logic [DW-1:0] read_data_out = '0;
  logic read_valid_out = 0, rsp_ready = 0;
  logic read_s, write_s, rsp_valid, rsp_write, rsp_err, busy;
  logic [$clog2(DEPTH):0] cmd_count;

  axi4_lite_cmd_sequencer #(.DATA_WIDTH(DW), .ADDRESS(AW), .DEPTH(DEPTH), .WR_WAIT(WR_WAIT), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .read_s(read_s), .write_s(write_s), .address(address),
    .W_data(W_data), .read_data_out(read_data_out), .read_valid_out(read_valid_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .cmd_count(cmd_count));

  always #5 ACLK = ~ACLK;

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; } cmd_t;
  typedef struct { logic w; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic w; logic [31:0] a; logic [31:0] d; int lat; logic glitch; logic ew; logic [31:0] ed; logic ee; } vec_t;

  int tests = 0, fails = 0, cyc = 0;
  cmd_t issue_q[$];
  rsp_t rsp_q[$];
  logic [31:0] ref_mem [64];
  logic [31:0] top_mem [64];
  int pulse_log[$], hs_log[$];
  int hs_count = 0, last_wr_pulse = 0, last_acc = 0, rd_lat = 1;
  logic inflight = 0, prev_rv = 0, prev_rvo = 0;
  logic lr_w, lr_e;
  logic [31:0] lr_d;
  logic rd_dead = 0, glitch = 0, rand_lat = 0, noise = 0, done_push = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 2000) begin @(negedge ACLK); n++; end
    check("push_accept", cmd_ready, 1);
    if (cmd_ready) begin
      last_acc = cyc;
      issue_q.push_back('{w, a, d});
      if (w) begin
        ref_mem[a[7:2]] = d;
        rsp_q.push_back('{1'b1, 32'h0, 1'b0});
      end else if (rd_dead) rsp_q.push_back('{1'b0, 32'h0, 1'b1});
      else rsp_q.push_back('{1'b0, ref_mem[a[7:2]], 1'b0});
    end
    @(negedge ACLK);
    cmd_valid = 0;
  endtask

  task automatic wait_hs(input int n);
    int k = 0;
    while (hs_count < n && k < 5000) begin @(negedge ACLK); k++; end
    check("response_arrived", hs_count >= n, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_read_s", read_s, 0);
    check("rst_write_s", write_s, 0);
    check("rst_address", address, 0);
    check("rst_W_data", W_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_count", cmd_count, 0);
  endtask

  initial forever begin @(posedge ACLK); cyc++; end

  // model of the AXI4-Lite top: memory, start pulses, delayed read_valid_out
  initial begin
    int t = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        t = 0;
        read_valid_out = 0;
      end else begin
        if (write_s) top_mem[address[7:2]] = W_data;
        if (read_s) begin
          t = rand_lat ? int'($urandom_range(1, 4)) : rd_lat;
          read_valid_out = glitch;
          read_data_out = 32'hBAD0BAD0;
        end else begin
          read_valid_out = (!rd_dead && t == 1) || (t == 0 && noise && $urandom_range(0, 3) == 0);
          read_data_out = (!rd_dead && t == 1) ? top_mem[address[7:2]] : $urandom;
          if (t > 0) t--;
        end
      end
    end
  end

  // protocol monitor and scoreboard
  initial begin
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge ACLK); #1;
      if (!ARESETN) begin
        inflight = 0; prev_rv = 0; prev_rvo = 0;
      end else begin
        check("start_exclusive", read_s && write_s, 0);
        check("busy", busy, inflight || read_s || write_s);
        check("cmd_ready_vs_count", cmd_ready, cmd_count < DEPTH);
        check("cmd_count_max", cmd_count <= DEPTH, 1);
        if (read_s || write_s) begin
          pulse_log.push_back(cyc);
          inflight = 1;
          check("start_has_cmd", issue_q.size() > 0, 1);
          if (issue_q.size() > 0) begin
            c = issue_q.pop_front();
            check("start_kind", write_s, c.w);
            check("start_addr", address, c.a);
            if (c.w) begin
              check("start_wdata", W_data, c.d);
              last_wr_pulse = cyc;
            end
          end
        end
        if (rsp_valid && !prev_rv) begin
          if (rsp_write) check("wr_latency", cyc - last_wr_pulse, WR_WAIT + 1);
          else if (!rsp_err) check("rd_latency", prev_rvo, 1);
        end
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", rsp_q.size() > 0, 1);
          if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            check("rsp_write", rsp_write, r.w);
            check("rsp_rdata", rsp_rdata, r.rdata);
            check("rsp_err", rsp_err, r.err);
          end
          lr_w = rsp_write; lr_d = rsp_rdata; lr_e = rsp_err;
          hs_log.push_back(cyc);
          hs_count++;
          inflight = 0;
        end
        prev_rv = rsp_valid;
        prev_rvo = read_valid_out;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, %0d tests so far", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int hs0, p0, n;
    logic sw, se, chg;
    logic [31:0] sd, sa;
    for (int i = 0; i < 64; i++) begin
      top_mem[i] = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0004, 32'h0000_00A5, 1, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         2, 1'b0, 1'b0, 32'h0000_00A5, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 1, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0,         3, 1'b0, 1'b0, 32'h1000_0002, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFF_FF08, 32'h0,         1, 1'b0, 1'b0, 32'h1000_0002, 1'b0};
    vecs[8]  = '{1'b1, 32'hA5A5_A5FC, 32'h1357_9BDF, 1, 1'b0, 1'b1, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_00FC, 32'h0,         2, 1'b0, 1'b0, 32'h1357_9BDF, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         1, 1'b1, 1'b0, 32'h1000_0000, 1'b0};

    repeat (3) @(negedge ACLK);
    check_reset_vals();
    ARESETN = 1;
    repeat (2) @(negedge ACLK);
    check_reset_vals();

    // table: one command at a time into an idle sequencer
    rsp_ready = 1;
    foreach (vecs[i]) begin
      rd_lat = vecs[i].lat;
      glitch = vecs[i].glitch;
      hs0 = hs_count;
      push(vecs[i].w, vecs[i].a, vecs[i].d);
      wait_hs(hs0 + 1);
      check("vec_issue_latency", pulse_log[$] - last_acc, 2);
      check("vec_rsp_write", lr_w, vecs[i].ew);
      check("vec_rsp_rdata", lr_d, vecs[i].ed);
      check("vec_rsp_err", lr_e, vecs[i].ee);
    end
    glitch = 0;
    rd_lat = 2;

    // back-to-back: one IDLE cycle between handshake and the next start
    pulse_log.delete();
    hs_log.delete();
    hs0 = hs_count;
    push(1, 32'h20, 32'h2222_0000);
    push(1, 32'h24, 32'h2424_0000);
    wait_hs(hs0 + 2);
    check("b2b_gap", pulse_log.size() == 2 && hs_log.size() >= 1 ? pulse_log[1] - hs_log[0] : -1, 2);

    // full FIFO with the client stalled
    rsp_ready = 0;
    hs0 = hs_count;
    push(0, 32'h04, 0);
    push(1, 32'h30, 32'h3030_3030);
    push(0, 32'h30, 0);
    push(1, 32'h34, 32'h3434_3434);
    push(0, 32'h10, 0);
    check("full_count", cmd_count, 4);
    check("full_ready", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
    check("hold_reached", rsp_valid, 1);
    sw = rsp_write; sd = rsp_rdata; se = rsp_err; sa = address;
    p0 = pulse_log.size();
    chg = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (rsp_write !== sw || rsp_rdata !== sd || rsp_err !== se || address !== sa || !rsp_valid) chg = 1;
    end
    check("hold_stable", chg, 0);
    check("hold_rdata", sd, 32'h0000_00A5);
    check("hold_no_start", pulse_log.size(), p0);
    check("hold_queue", cmd_count, 4);
    fork
      push(0, 32'h34, 0);
      begin repeat (5) @(negedge ACLK); rsp_ready = 1; end
    join
    wait_hs(hs0 + 6);

`ifdef AXIL_SEQ_TIMEOUT_EN
    rd_dead = 1;
    hs0 = hs_count;
    push(0, 32'h40, 0);
    wait_hs(hs0 + 1);
    check("timeout_err", lr_e, 1);
    check("timeout_rdata", lr_d, 0);
    rd_dead = 0;
`endif

    // random traffic with random client back-pressure and read latency
    rand_lat = 1;
    noise = 1;
    hs0 = hs_count;
    done_push = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          push(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FF1C, $urandom);
          repeat ($urandom_range(0, 3)) @(negedge ACLK);
        end
        done_push = 1;
      end
      begin
        while (!done_push) begin
          rsp_ready = $urandom_range(0, 3) != 0;
          @(negedge ACLK);
        end
        rsp_ready = 1;
      end
    join
    wait_hs(hs0 + 150);
    check("drain_issue", issue_q.size(), 0);
    check("drain_rsp", rsp_q.size(), 0);
    rand_lat = 0;
    noise = 0;

    // reset in WAIT_WR with two commands queued
    p0 = pulse_log.size();
    push(1, 32'h50, 32'h5050_5050);
    push(1, 32'h54, 32'h5454_5454);
    push(1, 32'h58, 32'h5858_5858);
    n = 0;
    while (pulse_log.size() == p0 && n < 50) begin @(negedge ACLK); n++; end
    repeat (2) @(negedge ACLK);
    check("pre_rst_queue", cmd_count, 2);
    check("pre_rst_busy", busy, 1);
    ARESETN = 0;
    #1;
    check_reset_vals();
    issue_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    p0 = pulse_log.size();
    repeat (30) @(negedge ACLK);
    check("post_rst_no_start", pulse_log.size(), p0);
    check("post_rst_count", cmd_count, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_rsp_valid", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi4_lite_cmd_sequencer.md
# axi4_lite_cmd_sequencer

Command sequencer sitting directly upstream of the AXI4-Lite master/slave top. It buffers read/write commands from a client in a small FIFO and issues them one at a time on the top's start/address/data inputs. It waits for each transaction to complete and returns one response per command, with read data, on a valid/ready channel.

## Interface
- DATA_WIDTH, 32, data width; must match the AXI4-Lite top
- ADDRESS, 32, address width; must match the AXI4-Lite top
- DEPTH, 4, command FIFO depth; power of two, ≥2
- WR_WAIT, 8, cycles from write start pulse to write completion; ≥1
- RD_TIMEOUT, 64, cycle limit for read completion; ≥2; used only with AXIL_SEQ_TIMEOUT_EN
- ACLK  in  1  clock; all logic on the rising edge
- ARESETN  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; high iff count < DEPTH
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDRESS  command address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- read_s  out  1  one-cycle read start pulse to the top
- write_s  out  1  one-cycle write start pulse to the top
- address  out  ADDRESS  transaction address to the top
- W_data  out  DATA_WIDTH  write data to the top
- read_data_out  in  DATA_WIDTH  read data from the top
- read_valid_out  in  1  read data valid from the top
- rsp_valid  out  1  response available
- rsp_ready  in  1  client accepts response
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_WIDTH  captured read data; 0 for writes and timeouts
- rsp_err  out  1  read timed out
- busy  out  1  high in any state except IDLE
- cmd_count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO: a push occurs when cmd_valid && cmd_ready. A pop occurs when the FSM leaves IDLE. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP.
- IDLE: when the FIFO is non-empty, pop the head into the command register and go to ISSUE.
- ISSUE (one cycle): assert read_s or write_s per cmd_write. address and W_data are driven from the command register. Next state is WAIT_RD for a read, WAIT_WR for a write.
- WAIT_RD: on read_valid_out, capture read_data_out into rsp_rdata with rsp_err=0, then go to RESP. read_valid_out sampled in ISSUE is ignored.
- WAIT_WR: a counter loads WR_WAIT−1 on entry and decrements each cycle. At 0, go to RESP with rsp_write=1, rsp_rdata=0, rsp_err=0.
- RESP: rsp_valid=1 and the response fields are held stable. On rsp_ready, go to IDLE. The FSM stalls in RESP while rsp_ready is low.
- address and W_data hold the command register from ISSUE through RESP, and retain their value in IDLE.
- read_s and write_s are never both high. Each is high only in ISSUE.
- A client push is accepted while the FSM is in any state.

## Timing
- Reset values: cmd_ready=1, read_s=0, write_s=0, address=0, W_data=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0, busy=0, cmd_count=0. The FSM resets to IDLE and the FIFO is emptied.
- Reset asserted mid-transaction aborts it immediately. Queued commands are discarded.
- A command pushed into an empty FIFO in cycle N pops in cycle N+1. ISSUE occurs in cycle N+2, with the read_s/write_s pulse in that cycle.
- Write response: rsp_valid rises WR_WAIT+1 cycles after the write_s pulse.
- Read response: rsp_valid rises the cycle after read_valid_out is sampled high.
- Back-to-back throughput: after the RESP handshake there is 1 IDLE cycle, then ISSUE on the following cycle.
- Full FIFO: cmd_ready=0. A push and pop in the same cycle on a full FIFO is impossible because cmd_ready is registered from count.

## Configuration
- AXIL_SEQ_TIMEOUT_EN defined: WAIT_RD runs a counter from ISSUE onward. If read_valid_out is not seen within RD_TIMEOUT cycles, the FSM goes to RESP with rsp_err=1 and rsp_rdata=0.
- AXIL_SEQ_TIMEOUT_EN not defined: WAIT_RD waits indefinitely and rsp_err is tied to 0. RD_TIMEOUT is unused.

## Test plan
- Reset, then a single write of addr 0x10, data 0xDEADBEEF: one write_s pulse with address=0x10 and W_data=0xDEADBEEF, then a response with rsp_write=1 and rsp_err=0 arriving WR_WAIT+1 cycles after the pulse.
- Write 0x0000_00A5 to 0x4, then read 0x4 with the top attached: read_s pulses once, and the response has rsp_rdata=0x0000_00A5, rsp_write=0, rsp_err=0.
- Push 5 commands with DEPTH=4 while rsp_ready=0: cmd_ready drops after the FIFO fills and cmd_count never exceeds 4. Then raise rsp_ready: all 5 responses arrive in order.
- Hold rsp_ready=0 for 20 cycles in RESP: response fields stay stable, no further start pulses occur, and queued commands remain.
- With AXIL_SEQ_TIMEOUT_EN defined and read_valid_out tied low, RD_TIMEOUT=64: the read response has rsp_err=1 and rsp_rdata=0.
- Assert ARESETN low during WAIT_WR with 2 commands queued: all outputs return to reset values, cmd_count=0, and no further pulses occur after release.
